// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter and sequencer for a small single-port on-chip RAM.
// After reset it zero-fills the RAM, then serializes m0/m1 accesses one transfer at a time.
module onchip_mem_arbiter #(
    parameter int ADDR_W         = 2,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                init_done
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACCESS, S_RDATA} state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    localparam logic   RST_DONE  = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_clr_cnt;
    logic                r_last_grant;
    logic                r_grant;
    logic                r_init_done;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [BE_W-1:0]     r_mem_byteenable;
    logic                r_mem_chipselect;
    logic                r_mem_write;
    logic [DATA_W-1:0]   r_mem_writedata;

    logic                w_req0;
    logic                w_req1;
    logic                w_win;
    logic [ADDR_W-1:0]   w_sel_address;
    logic [BE_W-1:0]     w_sel_byteenable;
    logic [DATA_W-1:0]   w_sel_writedata;
    logic                w_sel_write;

    // w_win = 1 selects m1; on a tie the master not granted last wins
    always_comb begin
        w_req0           = m0_read | m0_write;
        w_req1           = m1_read | m1_write;
        w_win            = w_req1 & (~w_req0 | ~r_last_grant);
        w_sel_address    = w_win ? m1_address    : m0_address;
        w_sel_byteenable = w_win ? m1_byteenable : m0_byteenable;
        w_sel_writedata  = w_win ? m1_writedata  : m0_writedata;
        w_sel_write      = w_win ? m1_write      : m0_write;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= RST_STATE;
            r_clr_cnt        <= '0;
            r_last_grant     <= 1'b1;
            r_grant          <= 1'b0;
            r_init_done      <= RST_DONE;
            r_mem_address    <= '0;
            r_mem_byteenable <= '0;
            r_mem_chipselect <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_writedata  <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_mem_chipselect <= 1'b1;
                    r_mem_write      <= 1'b1;
                    r_mem_address    <= ADDR_W'(r_clr_cnt);
                    r_mem_byteenable <= '1;
                    r_mem_writedata  <= '0;
                    if (r_clr_cnt == CNT_W'(DEPTH - 1)) begin
                        r_clr_cnt   <= '0;
                        r_init_done <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_mem_chipselect <= 1'b1;
                        r_mem_write      <= w_sel_write;
                        r_mem_address    <= w_sel_address;
                        r_mem_byteenable <= w_sel_byteenable;
                        r_mem_writedata  <= w_sel_writedata;
                        r_grant          <= w_win;
                        r_last_grant     <= w_win;
                        r_state          <= S_ACCESS;
                    end else begin
                        r_mem_chipselect <= 1'b0;
                        r_mem_write      <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    r_mem_chipselect <= 1'b0;
                    r_mem_write      <= 1'b0;
                    r_state          <= r_mem_write ? S_IDLE : S_RDATA;
                end
                S_RDATA: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m0_waitrequest   = !((r_state == S_ACCESS) && !r_grant);
    assign m1_waitrequest   = !((r_state == S_ACCESS) &&  r_grant);
    assign m0_readdatavalid = (r_state == S_RDATA) && !r_grant;
    assign m1_readdatavalid = (r_state == S_RDATA) &&  r_grant;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    assign mem_address    = r_mem_address;
    assign mem_byteenable = r_mem_byteenable;
    assign mem_chipselect = r_mem_chipselect;
    assign mem_write      = r_mem_write;
    assign mem_writedata  = r_mem_writedata;
    assign mem_clken      = 1'b1;
    assign init_done      = r_init_done;
endmodule
